// File: rtl/iccm_boot_loader.sv
// ICCM boot loader.
// Assembles little-endian 32-bit words from the boot UART byte stream and
// writes them sequentially into the ICCM. The SoC is held in reset while this
// happens. The system reset request is released after the end-of-program
// marker plus a fixed delay, or straight away when boot_sel_i asks to skip
// loading.
module iccm_boot_loader #(
  parameter int unsigned AddrWidth    = 13,
  parameter logic [31:0] EndMarker    = 32'h0000_0FFF,
  parameter int unsigned ReleaseDelay = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 boot_sel_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 iccm_req_o,
  output logic                 iccm_we_o,
  output logic [AddrWidth-1:0] iccm_addr_o,
  output logic [31:0]          iccm_wdata_o,
  output logic                 iccm_rst_o,
  output logic [AddrWidth:0]   words_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DELAY = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam logic [7:0] DelayInit = 8'(ReleaseDelay);

  state_e               state_q, state_d;
  logic                 skip_q, skip_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          shift_q, shift_d;
  logic [7:0]           dly_q, dly_d;
  logic [AddrWidth:0]   words_q, words_d;
  logic                 req_d;
  logic [AddrWidth-1:0] addr_d;
  logic [31:0]          wdata_d;

  // The word is only complete on the 4th byte, so lane 3 comes straight from
  // the incoming byte and only lanes 0..2 need storage.
  logic [31:0] word;
  logic        word_done;
  logic        is_marker;
  logic        is_full;

  assign word      = {rx_byte_i, shift_q};
  assign word_done = (state_q == LOAD) && rx_valid_i && (idx_q == 2'd3);
  assign is_marker = (word == EndMarker);
  // words_q never goes past 2^AddrWidth, so its top bit alone flags a full ICCM.
  assign is_full   = words_q[AddrWidth];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before the edge, whatever the statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: each combinational output gets a default first. No path can then
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // boot_sel_i is sampled on the first edge only. Skip costs a second
        // edge so that the release arrives on edge 2 after reset.
        if (skip_q) begin
          state_d = RUN;
        end else if (!boot_sel_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (word_done) begin
          if (is_marker) begin
            state_d = DELAY;
          end else if (is_full) begin
            state_d = ERROR;
          end
        end
      end
      DELAY: begin
        // The counter reaches zero on this edge.
        if (dly_q == 8'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        // RUN and ERROR are terminal until reset.
      end
    endcase
  end

  // Datapath and output next values: byte assembly, ICCM writes, delay count.
  always_comb begin
    skip_d  = skip_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dly_d   = dly_q;
    words_d = words_q;
    req_d   = 1'b0;
    addr_d  = iccm_addr_o;
    wdata_d = iccm_wdata_o;
    case (state_q)
      IDLE: begin
        if (boot_sel_i) begin
          skip_d = 1'b1;
        end
      end
      LOAD: begin
        if (rx_valid_i) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    shift_d[7:0]   = rx_byte_i;
            2'd1:    shift_d[15:8]  = rx_byte_i;
            2'd2:    shift_d[23:16] = rx_byte_i;
            default: ;
          endcase
          if (word_done) begin
            if (is_marker) begin
              dly_d = DelayInit;
            end else if (!is_full) begin
              req_d   = 1'b1;
              addr_d  = words_q[AddrWidth-1:0];
              wdata_d = word;
              words_d = words_q + 1'b1;
            end
          end
        end
      end
      DELAY: begin
        dly_d = dly_q - 8'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skip_q  <= 1'b0;
      idx_q   <= 2'd0;
      // NOTE: the partial-word register is reset along with everything else.
      // A reset in the middle of a word then cannot leak stale bytes into the
      // next load.
      shift_q <= 24'd0;
      dly_q   <= 8'd0;
      words_q <= '0;
    end else begin
      skip_q  <= skip_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dly_q   <= dly_d;
      words_q <= words_d;
    end
  end

  // Output registers. Status levels follow the state being entered, so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iccm_req_o   <= 1'b0;
      iccm_we_o    <= 1'b0;
      iccm_addr_o  <= '0;
      iccm_wdata_o <= 32'd0;
      iccm_rst_o   <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      iccm_req_o   <= req_d;
      iccm_we_o    <= req_d;
      iccm_addr_o  <= addr_d;
      iccm_wdata_o <= wdata_d;
      iccm_rst_o   <= (state_d == RUN);
      done_o       <= (state_d == RUN);
      err_o        <= (state_d == ERROR);
    end
  end

  assign words_o = words_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Self-checking bench for iccm_boot_loader. It drives two instances from the
// same inputs: the default ICCM size, and a 4-word ICCM for overflow.
// Expected writes come from a list-level model of the byte stream.
module tb_iccm_boot_loader;

  localparam logic [31:0] EndMark = 32'h0000_0FFF;
  localparam int          Rd      = 16;
  localparam int          AwA     = 13;
  localparam int          AwB     = 2;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       boot_sel;
  logic       rx_valid;
  logic [7:0] rx_byte;

  logic           a_req, a_we, a_rst, a_done, a_err;
  logic [AwA-1:0] a_addr;
  logic [31:0]    a_wdata;
  logic [AwA:0]   a_words;
  logic           b_req, b_we, b_rst, b_done, b_err;
  logic [AwB-1:0] b_addr;
  logic [31:0]    b_wdata;
  logic [AwB:0]   b_words;

  iccm_boot_loader dut_a (
    .clk_i(clk), .rst_ni(rst_n), .boot_sel_i(boot_sel),
    .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .iccm_req_o(a_req), .iccm_we_o(a_we), .iccm_addr_o(a_addr),
    .iccm_wdata_o(a_wdata), .iccm_rst_o(a_rst), .words_o(a_words),
    .done_o(a_done), .err_o(a_err)
  );

  iccm_boot_loader #(.AddrWidth(AwB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .boot_sel_i(boot_sel),
    .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .iccm_req_o(b_req), .iccm_we_o(b_we), .iccm_addr_o(b_addr),
    .iccm_wdata_o(b_wdata), .iccm_rst_o(b_rst), .words_o(b_words),
    .done_o(b_done), .err_o(b_err)
  );

  logic a_any, b_any;
  assign a_any = |{a_req, a_we, a_addr, a_wdata, a_rst, a_words, a_done, a_err};
  assign b_any = |{b_req, b_we, b_addr, b_wdata, b_rst, b_words, b_done, b_err};

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sent_q[$];
  wr_t        act_a[$];
  wr_t        act_b[$];
  wr_t        exp_q[$];
  int         exp_words;
  bit         exp_err;
  bit         exp_marker;

  // Write monitor: captures every write and checks that each req pulse is a
  // single cycle with we equal to req.
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;
  always @(negedge clk) begin
    if (a_req) act_a.push_back('{int'(a_addr), a_wdata});
    if (b_req) act_b.push_back('{int'(b_addr), b_wdata});
    if (a_req || a_we || a_prev) begin
      n_vec++;
      if (a_we !== a_req || (a_req && a_prev)) begin
        n_err++;
        $display("FAIL a_req_pulse: req=%b we=%b prev_req=%b, want single-cycle req with we==req", a_req, a_we, a_prev);
      end
    end
    if (b_req || b_we || b_prev) begin
      n_vec++;
      if (b_we !== b_req || (b_req && b_prev)) begin
        n_err++;
        $display("FAIL b_req_pulse: req=%b we=%b prev_req=%b, want single-cycle req with we==req", b_req, b_we, b_prev);
      end
    end
    a_prev = a_req;
    b_prev = b_req;
  end

  // Reference model: cut the sent byte list into 4-byte little-endian words
  // and apply the marker and capacity rules to the list.
  task automatic build_expected(input int aw);
    logic [31:0] w;
    exp_q.delete();
    exp_words  = 0;
    exp_err    = 0;
    exp_marker = 0;
    for (int i = 0; i + 3 < sent_q.size(); i += 4) begin
      if (exp_err || exp_marker) break;
      w = {sent_q[i+3], sent_q[i+2], sent_q[i+1], sent_q[i]};
      if (w == EndMark) exp_marker = 1;
      else if (exp_words == (1 << aw)) exp_err = 1;
      else begin
        exp_q.push_back('{exp_words, w});
        exp_words++;
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == EndMark) w = ~w;
    return w;
  endfunction

  // Returns at a negedge with reset just released and no edge seen yet.
  task automatic do_reset(input bit sel);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    boot_sel = sel;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    act_a.delete();
    act_b.delete();
    sent_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    sent_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(gap_max, 0));
  endtask

  logic [31:0] fixed_words[3] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001};

  task automatic test_reset();
    rst_n = 1'b1; boot_sel = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (a_any !== 1'b0) begin n_err++; $display("FAIL reset_a: outputs nonzero=%b, want 0", a_any); end
    n_vec++;
    if (b_any !== 1'b0) begin n_err++; $display("FAIL reset_b: outputs nonzero=%b, want 0", b_any); end
  endtask

  task automatic test_skip();
    do_reset(1'b1);
    @(negedge clk);
    n_vec++;
    if (a_rst !== 1'b0 || b_rst !== 1'b0) begin n_err++; $display("FAIL skip_edge1: rst a=%b b=%b, want 0", a_rst, b_rst); end
    @(negedge clk);
    n_vec++;
    if (a_rst !== 1'b1 || b_rst !== 1'b1 || a_done !== 1'b1) begin
      n_err++; $display("FAIL skip_edge2: rst a=%b b=%b done=%b, want 1", a_rst, b_rst, a_done);
    end
    boot_sel = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom()), 0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (act_a.size() != 0 || a_words !== '0 || a_rst !== 1'b1) begin
      n_err++; $display("FAIL skip_no_write: writes=%0d words=%0d rst=%b, want 0/0/1", act_a.size(), a_words, a_rst);
    end
  endtask

  task automatic test_load();
    do_reset(1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send_word(fixed_words[i], 0);
      n_vec++;
      if (a_req !== 1'b1 || int'(a_addr) != i || a_wdata !== fixed_words[i] || int'(a_words) != i + 1) begin
        n_err++;
        $display("FAIL load_word%0d: req=%b addr=%0d data=%h words=%0d, want 1/%0d/%h/%0d",
                 i, a_req, a_addr, a_wdata, a_words, i, fixed_words[i], i + 1);
      end
    end
    send_word(EndMark, 0);
    for (int j = 0; j <= Rd; j++) begin
      if (j > 0) @(negedge clk);
      n_vec++;
      if (a_rst !== (j == Rd) || a_done !== (j == Rd)) begin
        n_err++; $display("FAIL load_release_k+%0d: rst=%b done=%b, want %0d", j, a_rst, a_done, j == Rd);
      end
    end
    build_expected(AwA);
    n_vec++;
    if (act_a.size() != exp_q.size() || int'(a_words) != exp_words) begin
      n_err++; $display("FAIL load_count: writes=%0d words=%0d, want %0d", act_a.size(), a_words, exp_words);
    end
    for (int i = 0; i < exp_q.size() && i < act_a.size(); i++) begin
      n_vec++;
      if (act_a[i].addr != exp_q[i].addr || act_a[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL load_wr%0d: (%0d,%h), want (%0d,%h)", i, act_a[i].addr, act_a[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_byte_gaps();
    do_reset(1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_word(fixed_words[i], 20);
    for (int i = 0; i < 4; i++) send_word(rand_word(), 20);
    send_word(EndMark, 20);
    repeat (Rd + 2) @(negedge clk);
    build_expected(AwA);
    n_vec++;
    if (act_a.size() != exp_q.size() || int'(a_words) != exp_words || a_done !== 1'b1) begin
      n_err++; $display("FAIL gaps_a_count: writes=%0d words=%0d done=%b, want %0d/%0d/1", act_a.size(), a_words, a_done, exp_q.size(), exp_words);
    end
    for (int i = 0; i < exp_q.size() && i < act_a.size(); i++) begin
      n_vec++;
      if (act_a[i].addr != exp_q[i].addr || act_a[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL gaps_a_wr%0d: (%0d,%h), want (%0d,%h)", i, act_a[i].addr, act_a[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    build_expected(AwB);
    n_vec++;
    if (act_b.size() != exp_q.size() || b_err !== exp_err || b_rst !== 1'b0) begin
      n_err++; $display("FAIL gaps_b: writes=%0d err=%b rst=%b, want %0d/%b/0", act_b.size(), b_err, b_rst, exp_q.size(), exp_err);
    end
  endtask

  task automatic test_mid_reset();
    // dut_a is in RUN and dut_b in ERROR at this point; reset must clear both at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (a_any !== 1'b0 || b_any !== 1'b0) begin n_err++; $display("FAIL async_reset_run: a=%b b=%b nonzero, want 0", a_any, b_any); end
    @(negedge clk);
    act_a.delete(); act_b.delete(); sent_q.delete();
    boot_sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send_word(fixed_words[0], 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    n_vec++;
    if (a_words !== 14'd1) begin n_err++; $display("FAIL mid_pre: words=%0d, want 1", a_words); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (a_any !== 1'b0) begin n_err++; $display("FAIL async_reset_load: outputs nonzero=%b, want 0", a_any); end
    @(negedge clk);
    act_a.delete(); act_b.delete(); sent_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_word(fixed_words[i], 2);
    send_word(EndMark, 2);
    repeat (Rd + 2) @(negedge clk);
    build_expected(AwA);
    n_vec++;
    if (act_a.size() != exp_q.size() || a_done !== 1'b1) begin
      n_err++; $display("FAIL mid_reload_count: writes=%0d done=%b, want %0d/1", act_a.size(), a_done, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_a.size(); i++) begin
      n_vec++;
      if (act_a[i].addr != exp_q[i].addr || act_a[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL mid_reload_wr%0d: (%0d,%h), want (%0d,%h)", i, act_a[i].addr, act_a[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_word(rand_word(), 3);
    n_vec++;
    if (b_err !== 1'b0 || int'(b_words) != 4) begin n_err++; $display("FAIL ovf_full: err=%b words=%0d, want 0/4", b_err, b_words); end
    send_word(rand_word(), 3);
    send_word(EndMark, 0);
    repeat (Rd + 2) @(negedge clk);
    build_expected(AwB);
    n_vec++;
    if (act_b.size() != exp_q.size() || b_err !== 1'b1 || b_rst !== 1'b0 || b_done !== 1'b0 || int'(b_words) != exp_words) begin
      n_err++;
      $display("FAIL ovf_state: writes=%0d err=%b rst=%b done=%b words=%0d, want %0d/1/0/0/%0d",
               act_b.size(), b_err, b_rst, b_done, b_words, exp_q.size(), exp_words);
    end
    for (int i = 0; i < exp_q.size() && i < act_b.size(); i++) begin
      n_vec++;
      if (act_b[i].addr != exp_q[i].addr || act_b[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL ovf_wr%0d: (%0d,%h), want (%0d,%h)", i, act_b[i].addr, act_b[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_marker_first();
    do_reset(1'b0);
    @(negedge clk);
    send_word(EndMark, 0);
    for (int j = 0; j <= Rd; j++) begin
      if (j > 0) @(negedge clk);
      n_vec++;
      if (a_rst !== (j == Rd) || b_rst !== (j == Rd)) begin
        n_err++; $display("FAIL marker_first_k+%0d: rst a=%b b=%b, want %0d", j, a_rst, b_rst, j == Rd);
      end
    end
    n_vec++;
    if (act_a.size() != 0 || a_words !== '0 || a_done !== 1'b1) begin
      n_err++; $display("FAIL marker_first_state: writes=%0d words=%0d done=%b, want 0/0/1", act_a.size(), a_words, a_done);
    end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_load();
    test_byte_gaps();
    test_mid_reset();
    test_overflow();
    test_marker_first();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
